// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants, GF(2^8) arithmetic, S-boxes, key schedule step and FSM state type
package aes_pkg;
  localparam int DATA_W = 128;
  localparam int KEY_L = 128;
  localparam int NUM_ROUNDS = 10;
  localparam logic [0:10][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} fsm_t;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 7; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns unless last)
module aes_inv_round import aes_pkg::*; (
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] next_state
);
  logic [127:0] sb, ak, mc;
  for (genvar c = 0; c < 4; c++) begin : g_c
    logic [7:0] a0, a1, a2, a3;
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign sb[127-8*(4*c+r) -: 8] = inv_sbox(state[127-8*(4*((c-r+4)%4)+r) -: 8]);
    end
    assign a0 = ak[127-32*c -: 8];
    assign a1 = ak[119-32*c -: 8];
    assign a2 = ak[111-32*c -: 8];
    assign a3 = ak[103-32*c -: 8];
    assign mc[127-32*c -: 32] = {
      gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
      gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
      gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
      gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  end
  assign ak = sb ^ round_key;
  assign next_state = last_round ? ak : mc;
endmodule

// File: rtl/aes_128_decrypt.sv
// aes_128_decrypt: iterative AES-128 decryptor, 20-cycle latency; AES_DEC_KEY_CACHE_EN reuses the last key schedule (10-cycle latency)
module aes_128_decrypt import aes_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [KEY_L-1:0]  cipher_key,
  input  logic [DATA_W-1:0] cipher_text,
  output logic [DATA_W-1:0] plain_text,
  output logic              valid_out
);
  fsm_t st, nst;
  logic [127:0] rk [0:NUM_ROUNDS];
  logic [127:0] blk, ct_r, nk, rd;
  logic [3:0] rnd;
  logic accept, hit;
  assign nk = key_step(rk[rnd - 4'd1], RCON[rnd]);
  aes_inv_round u_round (
    .state(blk),
    .round_key(rk[rnd]),
    .last_round(rnd == 4'd0),
    .next_state(rd)
  );
`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_valid;
  assign hit = cache_valid && cipher_key == rk[0];
  // cache is valid once a full expansion finishes; a different key invalidates it
  always_ff @(posedge clk)
    if (reset) cache_valid <= 1'b0;
    else if (st == KEYEXP && rnd == 4'd10) cache_valid <= 1'b1;
    else if (accept && !hit) cache_valid <= 1'b0;
`else
  assign hit = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    st <= reset ? IDLE : nst;
  // next-state logic
  always_comb begin
    nst = st;
    case (st)
      IDLE:    nst = accept ? (hit ? ROUND : KEYEXP) : IDLE;
      KEYEXP:  nst = rnd == 4'd10 ? ROUND : KEYEXP;
      ROUND:   nst = rnd == 4'd0 ? IDLE : ROUND;
      default: nst = IDLE;
    endcase
  end
  // handshake outputs
  always_comb begin
    ready_in = st == IDLE;
    accept = ready_in && valid_in;
  end
  // key schedule, round state and result registers
  always_ff @(posedge clk)
    if (reset) begin
      rk <= '{default: '0};
      blk <= '0;
      ct_r <= '0;
      rnd <= '0;
      plain_text <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (st)
        IDLE: if (accept) begin
          rk[0] <= cipher_key;
          ct_r <= cipher_text;
          blk <= cipher_text ^ rk[NUM_ROUNDS];
          rnd <= hit ? 4'd9 : 4'd1;
        end
        KEYEXP: begin
          rk[rnd] <= nk;
          blk <= ct_r ^ nk;
          rnd <= rnd == 4'd10 ? 4'd9 : rnd + 4'd1;
        end
        ROUND: begin
          blk <= rd;
          rnd <= rnd - 4'd1;
          if (rnd == 4'd0) begin
            plain_text <= rd;
            valid_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_aes_128_decrypt.sv
// tb_aes_128_decrypt: scoreboard bench for aes_128_decrypt (latencies follow AES_DEC_KEY_CACHE_EN)
module tb_aes_128_decrypt;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P3 = 128'hffeeddccbbaa99887766554433221100;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 10;
`else
  localparam int HIT_LAT = 20;
`endif
  logic clk, reset, valid_in, ready_in, valid_out;
  logic [127:0] cipher_key, cipher_text, plain_text;
  int compared = 0, mismatched = 0, vcount = 0, dbl = 0;
  bit prev_v = 0;
  logic [127:0] sb_q [$];
  logic [7:0] sb_t [256];

  aes_128_decrypt dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .cipher_key(cipher_key), .cipher_text(cipher_text),
    .plain_text(plain_text), .valid_out(valid_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_out && prev_v) dbl++;
    if (valid_out) vcount++;
    prev_v = valid_out;
  end

  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = m2(x);
    end
    return r;
  endfunction
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb_t[x] = s;
    end
  endtask
  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_t[tmp[23:16]], sb_t[tmp[15:8]], sb_t[tmp[7:0]], sb_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc = m2(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) t[4*c+j] = sb_t[s[4*((c+j)%4)+j]];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = m2(a0) ^ mul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ m2(a1) ^ mul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ m2(a2) ^ mul(a3, 8'h03);
          t[4*c+3] = mul(a0, 8'h03) ^ a1 ^ a2 ^ m2(a3);
        end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic run(input string tag, input logic [127:0] k, input logic [127:0] ct,
                     input logic [127:0] pt, input int lat, input bit busy);
    int n;
    bit seen;
    check({tag, "_ready_idle"}, 128'(ready_in), 128'd1);
    cipher_key = k;
    cipher_text = ct;
    valid_in = 1;
    sb_q.push_back(pt);
    @(posedge clk);
    #1;
    valid_in = busy;
    cipher_text = busy ? ~ct : ct;
    seen = 0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (valid_out) seen = 1;
      else check({tag, "_ready_busy"}, 128'(ready_in), 128'd0);
    end
    valid_in = 0;
    compared++;
    assert (seen === 1'b1) else begin
      mismatched++;
      $error("FAIL %s_timeout: observed no valid_out expected valid_out within 40 cycles", tag);
    end
    if (!seen) void'(sb_q.pop_front());
    else begin
      check({tag, "_latency"}, 128'(n), 128'(lat));
      check({tag, "_ready_back"}, 128'(ready_in), 128'd1);
      check({tag, "_plain_text"}, plain_text, sb_q.pop_front());
    end
  endtask

  initial begin
    logic [127:0] k, p;
    int v0;
    build_sbox();
    reset = 1;
    valid_in = 0;
    cipher_key = 0;
    cipher_text = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_plain_text", plain_text, 128'd0);
    check("reset_valid_out", 128'(valid_out), 128'd0);
    check("reset_ready_in", 128'(ready_in), 128'd1);
    reset = 0;
    @(negedge clk);
    run("fips_c1", K1, C1, P1, 20, 0);
    repeat (3) @(negedge clk);
    run("fips_b", K2, C2, P2, 20, 0);
    repeat (3) @(negedge clk);
    v0 = vcount;
    run("busy", K1, C1, P1, 20, 1);
    repeat (2) @(negedge clk);
    check("busy_one_valid_out", 128'(vcount - v0), 128'd1);
    check("rst_ready_idle", 128'(ready_in), 128'd1);
    cipher_key = K2;
    cipher_text = C2;
    valid_in = 1;
    @(posedge clk);
    #1;
    valid_in = 0;
    v0 = vcount;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid_out", 128'(valid_out), 128'd0);
    check("midrst_plain_text", plain_text, 128'd0);
    check("midrst_ready_in", 128'(ready_in), 128'd1);
    check("midrst_no_pulse", 128'(vcount - v0), 128'd0);
    reset = 0;
    repeat (2) @(negedge clk);
    run("c1_after_reset", K1, C1, P1, 20, 0);
    repeat (3) @(negedge clk);
    run("same_key", K1, enc(K1, P3), P3, HIT_LAT, 0);
    repeat (3) @(negedge clk);
    run("b_key_change", K2, C2, P2, 20, 0);
    run("b2b_same_key", K2, C2, P2, HIT_LAT, 0);
    k = K2;
    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run("b2b_random", k, enc(k, p), p, 20, 0);
    end
    p = {$urandom, $urandom, $urandom, $urandom};
    run("b2b_random_repeat", k, enc(k, p), p, HIT_LAT, 0);
    repeat (3) @(negedge clk);
    check("no_double_valid_out", 128'(dbl), 128'd0);
    check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
